// File: rtl/gate3_bist.sv
// gate3_bist: self-test driver for a 3-input combinational library cell.
// Drives the cell inputs through all eight {A,B,C} vectors for PASSES sweeps.
// Each vector is held for SETTLE cycles, then the cell output Z is sampled
// and compared against the TRUTH table.
// The block reports completion, pass/fail, a saturating error count and the
// first failing vector.
//
// Optional feature: define GATE3_BIST_STOP_ON_FAIL_EN to end the run at the
// first mismatch. Left undefined, every vector of every pass is applied.
//
// Parameters:
//   TRUTH   expected Z per vector index {A,B,C}; the default is NAND3
//   SETTLE  cycles a vector is held before sampling (1..15)
//   PASSES  number of full 8-vector sweeps per run (1..15)
//   ERR_W   width of the error counter
//
// Ports:
//   CK       clock, rising edge
//   CD       asynchronous active-high reset
//   START    run request, sampled on CK, ignored while BUSY
//   A/B/C    cell inputs (vector index bits 2/1/0), registered
//   Z        cell output under test, same clock domain
//   BUSY     sweep in progress
//   DONE     run complete; level, held until the next START
//   PASS     DONE with zero mismatches
//   ERRCNT   saturating mismatch count
//   FAILVEC  first mismatching vector; nonzero only when DONE and not PASS
module gate3_bist #(
  parameter logic [7:0]  TRUTH  = 8'h7F,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             START,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             Z,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERRCNT,
  output logic [2:0]       FAILVEC
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 3;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] SWEEP_LAST  = CNT_W'(PASSES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = '1;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FIN
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] sweep_q, sweep_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [IDX_W-1:0] abc_q, abc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] errcnt_q, errcnt_d;
  logic [IDX_W-1:0] failvec_q, failvec_d;
  // Captured first failing index; only published on FAILVEC at the end of a run.
  logic [IDX_W-1:0] first_fail_q, first_fail_d;

  logic             mismatch_c;
  logic             last_c;
  logic             stop_c;
  logic [ERR_W-1:0] err_next_c;
  logic [IDX_W-1:0] first_fail_next_c;

  // State and output registers.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      sweep_q      <= '0;
      settle_q     <= '0;
      abc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      errcnt_q     <= '0;
      failvec_q    <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sweep_q      <= sweep_d;
      settle_q     <= settle_d;
      abc_q        <= abc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      errcnt_q     <= errcnt_d;
      failvec_q    <= failvec_d;
      first_fail_q <= first_fail_d;
    end
  end

  // Sample-cycle evaluation: compare, saturating count, first-fail capture.
  always_comb begin
    mismatch_c        = (Z != TRUTH[idx_q]);
    last_c            = (idx_q == IDX_LAST) && (sweep_q == SWEEP_LAST);
    err_next_c        = errcnt_q;
    first_fail_next_c = first_fail_q;
    if (mismatch_c) begin
      if (errcnt_q != ERR_MAX) begin
        err_next_c = errcnt_q + ERR_W'(1);
      end
      // A zero count means no mismatch has been seen yet in this run.
      if (errcnt_q == '0) begin
        first_fail_next_c = idx_q;
      end
    end
`ifdef GATE3_BIST_STOP_ON_FAIL_EN
    stop_c = last_c || mismatch_c;
`else
    stop_c = last_c;
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sweep_d      = sweep_q;
    settle_d     = settle_q;
    abc_d        = abc_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    errcnt_d     = errcnt_q;
    failvec_d    = failvec_q;
    first_fail_d = first_fail_q;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          state_d      = ST_SETTLE;
          idx_d        = '0;
          sweep_d      = '0;
          settle_d     = '0;
          abc_d        = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          errcnt_d     = '0;
          failvec_d    = '0;
          first_fail_d = '0;
        end
      end

      ST_SETTLE: begin
        settle_d = settle_q + CNT_W'(1);
        if (settle_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        errcnt_d     = err_next_c;
        first_fail_d = first_fail_next_c;
        settle_d     = '0;
        if (stop_c) begin
          state_d   = ST_FIN;
          abc_d     = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = (err_next_c == '0);
          failvec_d = (err_next_c == '0) ? '0 : first_fail_next_c;
        end else begin
          state_d = ST_SETTLE;
          idx_d   = idx_q + IDX_W'(1);
          abc_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            sweep_d = sweep_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign {A, B, C} = abc_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign ERRCNT    = errcnt_q;
  assign FAILVEC   = failvec_q;

endmodule

// File: tb/tb_gate3_bist.sv
// Testbench for gate3_bist: two instances, one with default parameters and one
// with PASSES=3 / ERR_W=2. Each instance tests a behavioural NAND3 whose output
// is flipped on the vectors selected by a fault mask.
module tb_gate3_bist;

  localparam int unsigned S_CYC  = 2;
  localparam int unsigned BUDGET = 400;

  logic       CK;
  logic       CD;
  logic       start1, start2;
  logic       a1, b1, c1, z1, busy1, done1, pass1;
  logic       a2, b2, c2, z2, busy2, done2, pass2;
  logic [7:0] errcnt1;
  logic [1:0] errcnt2;
  logic [2:0] failvec1, failvec2;
  logic [7:0] mask1, mask2;

  int errors = 0;
  int checks = 0;
  int sel    = 0;

  logic [2:0] o_abc;
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_err;
  logic [2:0] o_fv;

  gate3_bist dut1 (
    .CK(CK), .CD(CD), .START(start1), .A(a1), .B(b1), .C(c1), .Z(z1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERRCNT(errcnt1), .FAILVEC(failvec1)
  );

  gate3_bist #(.PASSES(3), .ERR_W(2)) dut2 (
    .CK(CK), .CD(CD), .START(start2), .A(a2), .B(b2), .C(c2), .Z(z2),
    .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERRCNT(errcnt2), .FAILVEC(failvec2)
  );

  // Behavioural NAND3, with faults injected on vectors selected by the mask.
  always_comb begin
    z1 = ~(a1 & b1 & c1) ^ mask1[{a1, b1, c1}];
    z2 = ~(a2 & b2 & c2) ^ mask2[{a2, b2, c2}];
  end

  always_comb begin
    if (sel == 0) begin
      o_abc = {a1, b1, c1}; o_busy = busy1; o_done = done1; o_pass = pass1;
      o_err = errcnt1; o_fv = failvec1;
    end else begin
      o_abc = {a2, b2, c2}; o_busy = busy2; o_done = done2; o_pass = pass2;
      o_err = {6'd0, errcnt2}; o_fv = failvec2;
    end
  end

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_abc"}, int'(o_abc), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_done"}, int'(o_done), 0);
    check({tag, "_pass"}, int'(o_pass), 0);
    check({tag, "_err"}, int'(o_err), 0);
    check({tag, "_fv"}, int'(o_fv), 0);
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start1 = v;
    else start2 = v;
  endtask

  // One run with the reference model computed from the mask.
  task automatic run(input int which, input logic [7:0] mask, input int repulse_at,
                     input string tag);
    int passes, ew, pop, low, exp_err, exp_done, n;
    bit got;
    passes = (which == 0) ? 1 : 3;
    ew     = (which == 0) ? 8 : 2;
    pop    = $countones(mask);
    low    = 0;
    for (int i = 7; i >= 0; i--) if (mask[i]) low = i;
`ifdef GATE3_BIST_STOP_ON_FAIL_EN
    exp_err  = (mask != 0) ? 1 : 0;
    exp_done = (mask != 0) ? (low + 1) * (S_CYC + 1) : 8 * passes * (S_CYC + 1);
`else
    exp_err  = pop * passes;
    if (exp_err > (1 << ew) - 1) exp_err = (1 << ew) - 1;
    exp_done = 8 * passes * (S_CYC + 1);
`endif
    @(negedge CK);
    sel = which;
    if (which == 0) mask1 = mask;
    else mask2 = mask;
    set_start(which, 1'b1);
    @(posedge CK);
    #1;
    check({tag, "_start_busy"}, int'(o_busy), 1);
    check({tag, "_start_done"}, int'(o_done), 0);
    check({tag, "_start_abc"}, int'(o_abc), 0);
    n   = 0;
    got = 0;
    while (!got && n < BUDGET) begin
      @(negedge CK);
      set_start(which, (n + 1 == repulse_at) ? 1'b1 : 1'b0);
      @(posedge CK);
      n++;
      #1;
      if (o_done) begin
        got = 1;
      end else if (n < exp_done) begin
        check({tag, "_abc"}, int'(o_abc), (n / (S_CYC + 1)) % 8);
        check({tag, "_busy"}, int'(o_busy), 1);
      end
    end
    check({tag, "_done_edge"}, n, exp_done);
    check({tag, "_pass"}, int'(o_pass), (mask == 0) ? 1 : 0);
    check({tag, "_errcnt"}, int'(o_err), exp_err);
    check({tag, "_failvec"}, int'(o_fv), (mask == 0) ? 0 : low);
    check({tag, "_fin_busy"}, int'(o_busy), 0);
    check({tag, "_fin_abc"}, int'(o_abc), 0);
    @(negedge CK);
    set_start(which, 1'b0);
    check({tag, "_done_held"}, int'(o_done), 1);
  endtask

  initial begin
    int  n;
    bit  seen;
    CD     = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    mask1  = 8'h00;
    mask2  = 8'h00;

    // Reset values.
    #12;
    sel = 0; check_zero("rst1");
    sel = 1; check_zero("rst2");
    @(negedge CK);
    CD = 1'b0;

    // Directed cases: good NAND3, stuck-at-1, stuck-at-0, wrap with saturation.
    run(0, 8'h00, 0, "good");
    run(0, 8'h80, 0, "stuck1");
    run(0, 8'h7F, 0, "stuck0");
    run(1, 8'h7F, 0, "wrap_sat");
    run(1, 8'h00, 0, "wrap_good");

    // Extra START while busy is ignored.
    run(0, 8'h00, 10, "repulse");

    // Mid-run reset while A/B/C=100, then a clean run.
    @(negedge CK);
    sel   = 0;
    mask1 = 8'h00;
    start1 = 1'b1;
    @(posedge CK);
    @(negedge CK);
    start1 = 1'b0;
    seen = 0;
    n    = 0;
    while (!seen && n < BUDGET) begin
      @(posedge CK);
      n++;
      #1;
      if (o_abc == 3'b100) seen = 1;
    end
    check("rst_mid_reached", int'(seen), 1);
    #2;
    CD = 1'b1;
    #1;
    sel = 0; check_zero("rst_mid1");
    sel = 1; check_zero("rst_mid2");
    @(negedge CK);
    CD = 1'b0;
    run(0, 8'h00, 0, "post_rst");

    // START held: DONE for one cycle, then a fresh run with a cleared count.
    @(negedge CK);
    sel    = 0;
    mask1  = 8'h80;
    start1 = 1'b1;
    @(posedge CK);
    n    = 0;
    seen = 0;
    while (!seen && n < BUDGET) begin
      @(posedge CK);
      n++;
      #1;
      if (o_done) seen = 1;
    end
    check("held_done_edge", n, 8 * (S_CYC + 1));
    check("held_err_fin", int'(o_err), 1);
    @(posedge CK);
    #1;
    check("held_done_drop", int'(o_done), 0);
    check("held_busy_rerun", int'(o_busy), 1);
    check("held_err_clear", int'(o_err), 0);
    check("held_abc_rerun", int'(o_abc), 0);
    @(negedge CK);
    start1 = 1'b0;
    n    = 0;
    seen = 0;
    while (!seen && n < BUDGET) begin
      @(posedge CK);
      n++;
      #1;
      if (o_done) seen = 1;
    end
    check("held_second_done", int'(seen), 1);
    check("held_second_fv", int'(o_fv), 7);

    // Randomised fault masks on both instances.
    for (int i = 0; i < 8; i++) begin
      run(i % 2, 8'($urandom), 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
